// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: internal width and rounding helpers,
// plus an elaboration-time twiddle generator that uses only integer arithmetic.
package fft_pkg;

    // Q28 fixed-point constants used only while the twiddle tables are generated
    localparam longint FX_ONE = 64'sd1 <<< 28;
    localparam longint FX_PI  = 64'sd843314857;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_TW_FRAC    = 10;

    // Internal add/sub width: two guard bits above the input width
    function automatic int int_width(input int data_width);
        return data_width + 2;
    endfunction

    // Half-LSB constant for round-half-up after dropping tw_frac bits
    function automatic longint round_const(input int tw_frac);
        return 64'sd1 <<< (tw_frac - 1);
    endfunction

    function automatic longint fx_mul(input longint a, input longint b);
        return (a * b) / FX_ONE;
    endfunction

    // round(2^frac * cos/sin(2*pi*k/n)) via Taylor series in Q28.
    // Angles stay below pi, so 16 terms are far more than enough.
    function automatic int tw_part(input int k, input int n, input int frac, input bit want_sin);
        longint th;
        longint th2;
        longint term;
        longint sum;
        longint val;
        th   = (2 * FX_PI * longint'(k)) / longint'(n);
        th2  = fx_mul(th, th);
        term = want_sin ? th : FX_ONE;
        sum  = term;
        for (int i = 1; i <= 16; i++) begin
            if (want_sin)
                term = -fx_mul(term, th2) / longint'((2 * i) * (2 * i + 1));
            else
                term = -fx_mul(term, th2) / longint'((2 * i - 1) * (2 * i));
            sum += term;
        end
        val = sum * (64'sd1 <<< frac);
        if (val >= 0)
            return int'((val + FX_ONE / 2) / FX_ONE);
        return -int'((-val + FX_ONE / 2) / FX_ONE);
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// N/2-entry twiddle ROM, W_k = cos - j*sin, filled at elaboration.
// Combinational read; INV selects the conjugate for inverse transforms.
module twiddle_rom
    import fft_pkg::*;
#(
    parameter int N_POINTS     = 8,
    parameter int TW_IDX_WIDTH = $clog2(N_POINTS) - 1,
    parameter int TW_WIDTH     = 12,
    parameter int TW_FRAC      = 10
) (
    input  logic [TW_IDX_WIDTH-1:0]   idx_i,
    input  logic                      inv_i,
    output logic signed [TW_WIDTH-1:0] w_re_o,
    output logic signed [TW_WIDTH-1:0] w_im_o
);

    localparam int HALF = N_POINTS / 2;
    localparam int HLOG = $clog2(N_POINTS) - 1;

    logic signed [TW_WIDTH-1:0] rom_re [HALF];
    logic signed [TW_WIDTH-1:0] rom_im [HALF];

    for (genvar g = 0; g < HALF; g++) begin : g_rom
        localparam int C = tw_part(g, N_POINTS, TW_FRAC, 1'b0);
        localparam int S = tw_part(g, N_POINTS, TW_FRAC, 1'b1);
        assign rom_re[g] = TW_WIDTH'(C);
        assign rom_im[g] = TW_WIDTH'(-S);
    end

    // Index is taken modulo N/2; conjugate by negating the imaginary part
    always_comb begin
        w_re_o = rom_re[idx_i[HLOG-1:0]];
        w_im_o = inv_i ? -rom_im[idx_i[HLOG-1:0]] : rom_im[idx_i[HLOG-1:0]];
    end

endmodule

// File: rtl/radix2_butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly with valid/ready backpressure:
// S1 operands + twiddle, S2 complex product, S3 add/sub, scale, saturate.
module radix2_butterfly_pipe
    import fft_pkg::*;
#(
    parameter int N_POINTS     = 8,
    parameter int TW_IDX_WIDTH = $clog2(N_POINTS) - 1,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH    = DATA_WIDTH + 1,
    parameter int TW_WIDTH     = 12,
    parameter int TW_FRAC      = DEF_TW_FRAC
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          IN_VALID,
    output logic                          IN_READY,
    input  logic signed [DATA_WIDTH-1:0]  IN0_Real,
    input  logic signed [DATA_WIDTH-1:0]  IN0_Img,
    input  logic signed [DATA_WIDTH-1:0]  IN1_Real,
    input  logic signed [DATA_WIDTH-1:0]  IN1_Img,
    input  logic [TW_IDX_WIDTH-1:0]       TW_Index,
    input  logic                          INV,
    input  logic                          SCALE,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic signed [OUT_WIDTH-1:0]   OUT0_Real,
    output logic signed [OUT_WIDTH-1:0]   OUT0_Img,
    output logic signed [OUT_WIDTH-1:0]   OUT1_Real,
    output logic signed [OUT_WIDTH-1:0]   OUT1_Img,
    output logic                          OVF,
    input  logic                          OVF_CLR
);

    localparam int IW = int_width(DATA_WIDTH);
    localparam int PW = DATA_WIDTH + TW_WIDTH + 1;
    localparam logic signed [PW-1:0] RND    = PW'(round_const(TW_FRAC));
    localparam logic signed [IW:0]   SAT_HI = (IW+1)'((64'sd1 <<< (OUT_WIDTH - 1)) - 1);
    localparam logic signed [IW:0]   SAT_LO = (IW+1)'(-(64'sd1 <<< (OUT_WIDTH - 1)));

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } cin_t;

    typedef struct packed {
        logic signed [IW-1:0] re;
        logic signed [IW-1:0] im;
    } cint_t;

    typedef struct packed {
        logic signed [OUT_WIDTH-1:0] re;
        logic signed [OUT_WIDTH-1:0] im;
    } cout_t;

    // Sum or difference of IN0 and the product at full internal width
    function automatic logic signed [IW:0] add_sub(input logic signed [DATA_WIDTH-1:0] a,
                                                   input logic signed [IW-1:0] p,
                                                   input logic sub);
        if (sub)
            return (IW+1)'(a) - (IW+1)'(p);
        return (IW+1)'(a) + (IW+1)'(p);
    endfunction

    // Optional divide-by-two with round half up
    function automatic logic signed [IW:0] half_scale(input logic signed [IW:0] v, input logic en);
        if (en)
            return (v + (IW+1)'(1)) >>> 1;
        return v;
    endfunction

    function automatic logic sat_hit(input logic signed [IW:0] v);
        return (v > SAT_HI) || (v < SAT_LO);
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [IW:0] v);
        if (v > SAT_HI)
            return OUT_WIDTH'(SAT_HI);
        if (v < SAT_LO)
            return OUT_WIDTH'(SAT_LO);
        return OUT_WIDTH'(v);
    endfunction

    logic en;

    logic vld_p1_q, vld_p2_q, vld_p3_q;
    logic vld_p1_d, vld_p2_d, vld_p3_d;
    logic ovf_q, ovf_d;

    logic signed [TW_WIDTH-1:0] w_re, w_im;

    cin_t                       a_p1_q, b_p1_q;
    logic signed [TW_WIDTH-1:0] wr_p1_q, wi_p1_q;
    logic                       scale_p1_q;

    cin_t                       a_p2_q;
    cint_t                      p_p2_q, p_d;
    logic                       scale_p2_q;
    logic signed [PW-1:0]       mr, mi;

    cout_t                      o0_p3_q, o1_p3_q, o0_d, o1_d;
    logic signed [IW:0]         s0r, s0i, s1r, s1i;
    logic                       sat_any;

    assign en        = !vld_p3_q || OUT_READY;
    assign IN_READY  = en;
    assign OUT_VALID = vld_p3_q;
    assign OVF       = ovf_q;
    assign OUT0_Real = o0_p3_q.re;
    assign OUT0_Img  = o0_p3_q.im;
    assign OUT1_Real = o1_p3_q.re;
    assign OUT1_Img  = o1_p3_q.im;

    twiddle_rom #(
        .N_POINTS     (N_POINTS),
        .TW_IDX_WIDTH (TW_IDX_WIDTH),
        .TW_WIDTH     (TW_WIDTH),
        .TW_FRAC      (TW_FRAC)
    ) u_rom (
        .idx_i  (TW_Index),
        .inv_i  (INV),
        .w_re_o (w_re),
        .w_im_o (w_im)
    );

    // ---- S1: capture operands, scale flag and (possibly conjugated) twiddle
    always_ff @(posedge CLK) begin
        if (en) begin
            a_p1_q     <= '{re: IN0_Real, im: IN0_Img};
            b_p1_q     <= '{re: IN1_Real, im: IN1_Img};
            wr_p1_q    <= w_re;
            wi_p1_q    <= w_im;
            scale_p1_q <= SCALE;
        end
    end

    // Complex product with round-half-up back to the twiddle-free scale
    always_comb begin
        mr      = PW'(b_p1_q.re) * PW'(wr_p1_q) - PW'(b_p1_q.im) * PW'(wi_p1_q);
        mi      = PW'(b_p1_q.re) * PW'(wi_p1_q) + PW'(b_p1_q.im) * PW'(wr_p1_q);
        p_d.re  = IW'((mr + RND) >>> TW_FRAC);
        p_d.im  = IW'((mi + RND) >>> TW_FRAC);
    end

    // ---- S2: register product alongside IN0 and the scale flag
    always_ff @(posedge CLK) begin
        if (en) begin
            a_p2_q     <= a_p1_q;
            p_p2_q     <= p_d;
            scale_p2_q <= scale_p1_q;
        end
    end

    // Butterfly add/sub, optional halving, saturation and overflow detect
    always_comb begin
        s0r     = half_scale(add_sub(a_p2_q.re, p_p2_q.re, 1'b0), scale_p2_q);
        s0i     = half_scale(add_sub(a_p2_q.im, p_p2_q.im, 1'b0), scale_p2_q);
        s1r     = half_scale(add_sub(a_p2_q.re, p_p2_q.re, 1'b1), scale_p2_q);
        s1i     = half_scale(add_sub(a_p2_q.im, p_p2_q.im, 1'b1), scale_p2_q);
        o0_d    = '{re: saturate(s0r), im: saturate(s0i)};
        o1_d    = '{re: saturate(s1r), im: saturate(s1i)};
        sat_any = sat_hit(s0r) || sat_hit(s0i) || sat_hit(s1r) || sat_hit(s1i);
    end

    // Stage valids advance together on EN; OVF set has priority over clear
    always_comb begin
        vld_p1_d = vld_p1_q;
        vld_p2_d = vld_p2_q;
        vld_p3_d = vld_p3_q;
        if (en) begin
            vld_p1_d = IN_VALID;
            vld_p2_d = vld_p1_q;
            vld_p3_d = vld_p2_q;
        end
        ovf_d = ovf_q && !OVF_CLR;
        if (en && vld_p2_q && sat_any)
            ovf_d = 1'b1;
    end

    // Control state: valids and sticky overflow flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            ovf_q    <= ovf_d;
        end
    end

    // ---- S3: output registers, cleared on reset and loaded only by real beats
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            o0_p3_q <= '0;
            o1_p3_q <= '0;
        end else if (en && vld_p2_q) begin
            o0_p3_q <= o0_d;
            o1_p3_q <= o1_d;
        end
    end

endmodule
